// File: rtl/imem_dmem_arb.sv
// Arbitrates the fetch (I) and load/store (D) ports onto one in-order memory port.
// A tag FIFO remembers each request's source so responses are routed back in order.
module imem_dmem_arb #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] im_req_addr,
    input  logic        im_req_valid,
    output logic        im_req_ready,
    output logic [63:0] im_resp_rdata,
    output logic        im_resp_valid,
    input  logic        im_flush,
    input  logic [63:0] dm_req_addr,
    input  logic [63:0] dm_req_wdata,
    input  logic [7:0]  dm_req_wmask,
    input  logic        dm_req_wen,
    input  logic        dm_req_valid,
    output logic        dm_req_ready,
    output logic [63:0] dm_resp_rdata,
    output logic        dm_resp_valid,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    output logic        mem_req_wen,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    input  logic [63:0] mem_resp_rdata,
    input  logic        mem_resp_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [DEPTH-1:0] r_src;      // 1 = I entry, 0 = D entry
    logic [DEPTH-1:0] r_drop;
    logic [CW-1:0]    r_starve;

    logic             w_full;
    logic             w_empty;
    logic             w_open;
    logic             w_grant_i;
    logic             w_hs;
    logic             w_pop;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_head_src;
    logic             w_head_drop;
    logic [DEPTH-1:0] w_drop_next;

    assign w_wr_idx = r_wptr[AW-1:0];
    assign w_rd_idx = r_rptr[AW-1:0];
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (w_wr_idx == w_rd_idx);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_open   = !w_full && !rst;

    // D has priority unless I has been passed over MAX_WAIT times in a row.
    assign w_grant_i = im_req_valid && (!dm_req_valid || (r_starve == MAX_CNT));

    assign mem_req_valid = (im_req_valid || dm_req_valid) && w_open;
    assign im_req_ready  = w_grant_i && mem_req_ready && w_open;
    assign dm_req_ready  = !w_grant_i && dm_req_valid && mem_req_ready && w_open;
    assign w_hs          = mem_req_valid && mem_req_ready;

    assign mem_req_addr  = w_grant_i ? im_req_addr : dm_req_addr;
    assign mem_req_wdata = w_grant_i ? 64'd0 : dm_req_wdata;
    assign mem_req_wmask = w_grant_i ? 8'd0 : dm_req_wmask;
    assign mem_req_wen   = w_grant_i ? 1'b0 : dm_req_wen;

    // Responses with nothing outstanding (e.g. from before reset) are ignored.
    assign w_pop       = mem_resp_valid && !w_empty && !rst;
    assign w_head_src  = r_src[w_rd_idx];
    assign w_head_drop = r_drop[w_rd_idx];

    assign dm_resp_valid = w_pop && !w_head_src;
    assign im_resp_valid = w_pop && w_head_src && !w_head_drop && !im_flush;
    assign im_resp_rdata = mem_resp_rdata;
    assign dm_resp_rdata = mem_resp_rdata;

    // A flush marks resident I entries; the slot being pushed this cycle starts clean.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_drop
            assign w_drop_next[gi] = (w_hs && (w_wr_idx == AW'(gi))) ? 1'b0
                                   : (r_drop[gi] || (im_flush && r_src[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_drop <= '0;
        end else begin
            r_drop <= w_drop_next;
            if (w_hs) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_src[w_wr_idx] <= w_grant_i;
        end
    end

    // Holds through memory stalls so the grant does not flip while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!im_req_valid || (w_hs && w_grant_i)) begin
            r_starve <= '0;
        end else if (w_hs && (r_starve != MAX_CNT)) begin
            r_starve <= r_starve + CW'(1);
        end
    end
endmodule
